// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the generic pipeline-stage register: skid mode
// selectors, occupancy width, control-state encodings and a helper that
// maps the control state onto the occupancy count.
package pipe_pkg;

  localparam int PIPE_NOSKID = 0;
  localparam int PIPE_SKID   = 1;
  localparam int OCC_W       = 2;

  // Control state: bit 1 = main entry valid, bit 0 = skid entry valid.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_TWO   = 2'b11;

  function automatic logic [OCC_W-1:0] occ_of_state(input logic [1:0] st);
    logic [OCC_W-1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_TWO:   occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/dff.sv
// Enable-capable D flip-flop vector with synchronous active-high reset to a
// configurable value. Reset wins over enable; without enable the value holds.
module dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage: reset first, then enable-gated load.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pipe_stage_reg_ctrl.sv
// Valid/state control for the pipeline-stage register. Tracks which entries
// are held, derives the handshake outputs and produces the write enables and
// the skid-to-main select for the datapath.
module pipe_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int SKID = PIPE_NOSKID
) (
  input  logic             clk,
  input  logic             rst_n,      // active-high synchronous reset
  input  logic             flush,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             main_we,
  output logic             skid_we,
  output logic             main_sel_skid,
  output logic [OCC_W-1:0] occupancy
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       in_ready_s;
  logic       out_valid_s;
  logic       accept_s;
  logic       release_s;

  // With a skid entry the ready depends only on held state, so the
  // downstream ready never reaches the upstream ready combinationally.
  if (SKID == PIPE_SKID) begin : g_rdy_skid
    assign in_ready_s = ~rst_n & ~state_q[0];
  end else begin : g_rdy_noskid
    assign in_ready_s = ~rst_n & (~state_q[1] | out_ready);
  end

  assign out_valid_s = ~rst_n & state_q[1];
  assign accept_s    = in_valid & in_ready_s;
  assign release_s   = out_valid_s & out_ready;

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign occupancy = occ_of_state(state_q);

  // Next-state and datapath enables; flush drops every entry and suppresses
  // all data writes so the payload registers keep their contents.
  always_comb begin
    state_d       = state_q;
    main_we       = 1'b0;
    skid_we       = 1'b0;
    main_sel_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d = ST_ONE;
            main_we = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && release_s) begin
            state_d = ST_ONE;
            main_we = 1'b1;
          end else if (accept_s) begin
            // Only reachable with a skid entry: park the new payload there.
            if (SKID == PIPE_SKID) begin
              state_d = ST_TWO;
              skid_we = 1'b1;
            end else begin
              state_d = ST_ONE;
            end
          end else if (release_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (release_s) begin
            state_d       = ST_ONE;
            main_we       = 1'b1;
            main_sel_skid = 1'b1;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State register; reset returns to EMPTY.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic parametrised pipeline-stage register with valid/ready handshake,
// synchronous flush and optional two-entry skid buffering. Stage-specific
// fields are concatenated into the payload by the instantiating stage.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               SKID      = PIPE_NOSKID,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,      // active-high synchronous reset
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic             main_we_s;
  logic             skid_we_s;
  logic             main_sel_skid_s;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  pipe_stage_ctrl #(
    .SKID (SKID)
  ) u_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .out_ready     (out_ready),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .main_we       (main_we_s),
    .skid_we       (skid_we_s),
    .main_sel_skid (main_sel_skid_s),
    .occupancy     (occupancy)
  );

  // Main entry source: the parked skid payload when draining TWO, else upstream.
  always_comb begin
    if (main_sel_skid_s) begin
      main_d = skid_q;
    end else begin
      main_d = in_data;
    end
  end

  dff #(
    .W       (WIDTH),
    .RST_VAL (RESET_VAL)
  ) u_main (
    .clk (clk),
    .rst (rst_n),
    .en  (main_we_s),
    .d   (main_d),
    .q   (main_q)
  );

  if (SKID == PIPE_SKID) begin : g_skid
    dff #(
      .W       (WIDTH),
      .RST_VAL (RESET_VAL)
    ) u_skid (
      .clk (clk),
      .rst (rst_n),
      .en  (skid_we_s),
      .d   (in_data),
      .q   (skid_q)
    );
  end else begin : g_noskid
    logic unused_skid_we_s;
    assign unused_skid_we_s = skid_we_s;
    assign skid_q           = RESET_VAL;
  end

  assign out_data = main_q;

endmodule
